// File: rtl/ebi_read_responder_pkg.sv
// Shared display definitions: EBI bank codes, status register offsets and
// the read-responder state encoding.
package ebi_read_responder_pkg;

    typedef enum logic [2:0] {
        BANK_OAM     = 3'd0,
        BANK_SPRITE  = 3'd1,
        BANK_TILE    = 3'd2,
        BANK_PALETTE = 3'd3,
        BANK_TAM     = 3'd4,
        BANK_STATUS  = 3'd7
    } ebi_bank_t;

    localparam logic [1:0] STAT_VBLANK = 2'd0;
    localparam logic [1:0] STAT_LINE   = 2'd1;
    localparam logic [1:0] STAT_FRAME  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOCAL = 3'd3,
        ST_DRIVE = 3'd4,
        ST_TURN  = 3'd5
    } ebi_rd_state_t;

endpackage

// File: rtl/ebi_read_responder_sync_bit.sv
// N-stage single-bit synchroniser with a configurable reset value; shared
// with the EBI write receiver.
module sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ebi_read_responder.sv
// EBI read-cycle responder: decodes MCU reads, fetches the word from the
// memory mux or the local status bank and drives it back onto EBI_AD.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for synced RE falling edge
// REQ      | one-cycle rd_req to the memory mux
// WAIT     | waiting for rd_ack, bounded by the timeout counter
// LOCAL    | loading the status word
// DRIVE    | driving data_q onto EBI_AD until RE rises
// TURN     | one bus-turnaround cycle with the pads released
module ebi_read_responder
    import ebi_read_responder_pkg::*;
#(
    parameter int          SYNC_STAGES  = 2,
    parameter int          TIMEOUT      = 15,
    parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD,
    parameter logic [2:0]  STATUS_BANK  = BANK_STATUS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ebi_ad_in,
    output logic [15:0] ebi_ad_out,
    output logic        ebi_ad_oe,
    input  logic        EBI_ALE,
    input  logic        EBI_RE,
    input  logic [2:0]  bank_select,
    output logic        rd_req,
    output logic [2:0]  rd_bank,
    output logic [15:0] rd_addr,
    input  logic        rd_ack,
    input  logic [15:0] rd_data,
    input  logic [9:0]  sy,
    input  logic        frame_done,
    output logic        busy
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // WAIT is entered one cycle after rd_req, so it lasts TIMEOUT-1 cycles.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 2);

    logic        ale_s;
    logic        re_s;
    logic [15:0] ad_s;

    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ale (
        .clk(clk), .reset(reset), .d(EBI_ALE), .q(ale_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_re (
        .clk(clk), .reset(reset), .d(EBI_RE), .q(re_s)
    );

    for (genvar i = 0; i < 16; i++) begin : g_ad_pipe
        sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ad (
            .clk(clk), .reset(reset), .d(ebi_ad_in[i]), .q(ad_s[i])
        );
    end

    ebi_rd_state_t    state_q, state_d;
    logic             re_prev_q, re_prev_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      data_q, data_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       rd_bank_q, rd_bank_d;
    logic [15:0]      rd_addr_q, rd_addr_d;
    logic             vblank_q, vblank_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      status_word;
    logic             re_fall;

    assign re_fall = re_prev_q & ~re_s;

    // Status reads use next-state values so a coincident frame_done is visible.
    always_comb begin
        vblank_d    = frame_done ? 1'b1 : ((sy == 10'd0) ? 1'b0 : vblank_q);
        frame_cnt_d = frame_done ? frame_cnt_q + 16'd1 : frame_cnt_q;
        case (addr_q[1:0])
            STAT_VBLANK: status_word = {15'd0, vblank_d};
            STAT_LINE:   status_word = {6'd0, sy};
            STAT_FRAME:  status_word = frame_cnt_d;
            default:     status_word = 16'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        re_prev_d = re_s;
        addr_d    = ale_s ? ad_s : addr_q;
        data_d    = data_q;
        tmr_d     = tmr_q;
        rd_bank_d = rd_bank_q;
        rd_addr_d = rd_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (re_fall) begin
                    if (bank_select == STATUS_BANK) begin
                        state_d = ST_LOCAL;
                    end else begin
                        state_d   = ST_REQ;
                        rd_bank_d = bank_select;
                        rd_addr_d = addr_q;
                    end
                end
            end
            ST_REQ: begin
                tmr_d   = TMR_LOAD;
                state_d = re_s ? ST_TURN : ST_WAIT;
            end
            ST_WAIT: begin
                if (re_s) begin
                    state_d = ST_TURN;
                end else if (rd_ack) begin
                    data_d  = rd_data;
                    state_d = ST_DRIVE;
                end else if (tmr_q == '0) begin
                    data_d  = TIMEOUT_DATA;
                    state_d = ST_DRIVE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_LOCAL: begin
                if (re_s) begin
                    state_d = ST_TURN;
                end else begin
                    data_d  = status_word;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (ale_s || re_s) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            re_prev_q   <= 1'b1;
            addr_q      <= 16'd0;
            data_q      <= 16'd0;
            tmr_q       <= '0;
            rd_bank_q   <= 3'd0;
            rd_addr_q   <= 16'd0;
            vblank_q    <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            re_prev_q   <= re_prev_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            tmr_q       <= tmr_d;
            rd_bank_q   <= rd_bank_d;
            rd_addr_q   <= rd_addr_d;
            vblank_q    <= vblank_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // A synced ALE while driving is a bus conflict: release the pads immediately.
    assign ebi_ad_oe  = (state_q == ST_DRIVE) && !ale_s;
    assign ebi_ad_out = data_q;
    assign rd_req     = (state_q == ST_REQ);
    assign rd_bank    = rd_bank_q;
    assign rd_addr    = rd_addr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
